// File: rtl/branch_update_scheduler_if.sv
// Branch update scheduler bus.
// Groups the resolve handshake, the decode lookup request/grant, the shared
// predictor-table port and the status outputs (flush, pending, mispredict_cnt).
//   master : the environment (mem stage, decode stage, predictor table)
//   slave  : the scheduler itself
interface branch_update_scheduler_if;
    logic        resolve_valid;
    logic [2:0]  resolve_idx;
    logic        resolve_taken;
    logic        resolve_pred;
    logic        resolve_ready;

    logic        lookup_req;
    logic [2:0]  lookup_idx;
    logic        lookup_grant;

    logic        tbl_en;
    logic        tbl_we;
    logic [2:0]  tbl_idx;
    logic        tbl_taken;

    logic        flush;
    logic [2:0]  pending;
    logic [15:0] mispredict_cnt;

    modport master (
        output resolve_valid, resolve_idx, resolve_taken, resolve_pred,
        output lookup_req, lookup_idx,
        input  resolve_ready, lookup_grant,
        input  tbl_en, tbl_we, tbl_idx, tbl_taken,
        input  flush, pending, mispredict_cnt
    );

    modport slave (
        input  resolve_valid, resolve_idx, resolve_taken, resolve_pred,
        input  lookup_req, lookup_idx,
        output resolve_ready, lookup_grant,
        output tbl_en, tbl_we, tbl_idx, tbl_taken,
        output flush, pending, mispredict_cnt
    );
endinterface

// File: rtl/branch_update_scheduler.sv
// Branch update scheduler.
// Queues resolved branch records {idx, taken} in a 4-entry FIFO and shares a
// single predictor-table port between decode-stage lookups and queued
// updates. A misprediction pulses flush for one cycle and holds the FSM in
// FLUSH for two cycles, during which lookups are blocked and updates drain.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : branch_update_scheduler_if.slave (resolve, lookup, table port,
//           flush, pending, mispredict_cnt)
module branch_update_scheduler (
    input  logic                       clk,
    input  logic                       reset,
    branch_update_scheduler_if.slave   bus
);
    localparam int DEPTH = 4;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t      state_q, state_d;
    logic        flush_first_q, flush_first_d;  // high during the first FLUSH cycle
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  pending_q, pending_d;
    logic        flush_q, flush_d;
    logic [15:0] cnt_q, cnt_d;

    // FIFO storage has no reset: contents are only observed behind pending.
    logic [2:0]  mem_idx_q   [DEPTH];
    logic        mem_taken_q [DEPTH];

    logic full, empty, upd_priority;
    logic push, pop, mispredict;
    logic ready, lgrant;

    always_comb begin
        full         = (pending_q == 3'd4);
        empty        = (pending_q == 3'd0);
        // A full queue or a flush in progress lets the update path win.
        upd_priority = full || (state_q == ST_FLUSH);

        ready  = !reset && !full;
        push   = bus.resolve_valid && ready;
        // Pop is decided from registered occupancy only, so a record pushed
        // into an empty FIFO is never popped in the same cycle.
        pop    = !reset && !empty && (upd_priority || !bus.lookup_req);
        lgrant = !reset && !upd_priority && bus.lookup_req;

        mispredict = push && (bus.resolve_taken != bus.resolve_pred);
    end

    assign bus.resolve_ready  = ready;
    assign bus.lookup_grant   = lgrant;
    assign bus.tbl_en         = pop || lgrant;
    assign bus.tbl_we         = pop;
    assign bus.tbl_idx        = pop ? mem_idx_q[rd_ptr_q] : bus.lookup_idx;
    assign bus.tbl_taken      = pop ? mem_taken_q[rd_ptr_q] : 1'b0;
    assign bus.flush          = flush_q;
    assign bus.pending        = pending_q;
    assign bus.mispredict_cnt = cnt_q;

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            pending_d = pending_q + 3'd1;
        end else if (pop && !push) begin
            pending_d = pending_q - 3'd1;
        end
    end

    // FSM next state, flush pulse and misprediction counter.
    always_comb begin
        state_d       = state_q;
        flush_first_d = flush_first_q;
        flush_d       = mispredict;
        cnt_d         = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d       = ST_FLUSH;
                    flush_first_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (mispredict) begin
                    // Another misprediction restarts the two-cycle window.
                    flush_first_d = 1'b1;
                end else if (flush_first_q) begin
                    flush_first_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d       = ST_RUN;
                flush_first_d = 1'b0;
            end
        endcase

        if (mispredict && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_first_q <= 1'b0;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            pending_q     <= 3'd0;
            flush_q       <= 1'b0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            flush_first_q <= flush_first_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pending_q     <= pending_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_idx_q[wr_ptr_q]   <= bus.resolve_idx;
            mem_taken_q[wr_ptr_q] <= bus.resolve_taken;
        end
    end
endmodule

// File: tb/tb_branch_update_scheduler.sv
// Scoreboard bench for branch_update_scheduler. A queue-based reference model
// predicts the per-cycle port behaviour; every accepted record is pushed onto
// an expected-write queue that a separate monitor pops whenever the DUT
// performs a table write.
module tb_branch_update_scheduler;
    logic clk;
    logic reset;

    branch_update_scheduler_if bus ();

    branch_update_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] idx;
        logic       taken;
    } rec_t;

    int   checks = 0;
    int   errors = 0;
    bit   verbose = 1'b1;

    // Reference model state.
    rec_t model_q [$];
    rec_t wr_exp  [$];
    int   flush_left = 0;   // FLUSH cycles still to come
    bit   flush_out  = 1'b0;
    int   mis_cnt    = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: compare this cycle's outputs, then apply the coming clock edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready", bus.resolve_ready, 0);
            chk("rst_lgrant", bus.lookup_grant, 0);
            chk("rst_tbl_en", bus.tbl_en, 0);
            chk("rst_pending", bus.pending, 0);
            chk("rst_flush", bus.flush, 0);
            chk("rst_cnt", bus.mispredict_cnt, 0);
            model_q.delete();
            wr_exp.delete();
            flush_left = 0;
            flush_out  = 1'b0;
            mis_cnt    = 0;
        end else begin
            bit   exp_ready, prio, exp_upd, exp_lg, accept, mis;
            rec_t r;
            exp_ready = (model_q.size() != 4);
            prio      = (model_q.size() == 4) || (flush_left > 0);
            exp_upd   = (model_q.size() > 0) && (prio || !bus.lookup_req);
            exp_lg    = !prio && bus.lookup_req;

            chk("ready", bus.resolve_ready, exp_ready);
            chk("lookup_grant", bus.lookup_grant, exp_lg);
            chk("tbl_en", bus.tbl_en, exp_upd || exp_lg);
            chk("tbl_we", bus.tbl_we, exp_upd);
            if (exp_lg) chk("tbl_idx_lookup", bus.tbl_idx, bus.lookup_idx);
            chk("flush", bus.flush, flush_out);
            chk("pending", bus.pending, model_q.size());
            chk("mis_cnt", bus.mispredict_cnt, mis_cnt);

            accept = bus.resolve_valid && exp_ready;
            mis    = accept && (bus.resolve_taken != bus.resolve_pred);
            if (exp_upd) void'(model_q.pop_front());
            if (accept) begin
                r.idx   = bus.resolve_idx;
                r.taken = bus.resolve_taken;
                model_q.push_back(r);
                wr_exp.push_back(r);
                if (verbose)
                    $display("push idx=%0d taken=%0d pred=%0d pending_after=%0d t=%0t",
                             r.idx, r.taken, bus.resolve_pred, model_q.size(), $time);
            end
            flush_out = mis;
            if (mis) flush_left = 2;
            else if (flush_left > 0) flush_left--;
            if (mis && mis_cnt < 16'hFFFF) mis_cnt++;
        end
    end

    // Monitor: every table write must match the oldest outstanding record.
    always @(negedge clk) begin
        if (!reset && bus.tbl_en === 1'b1 && bus.tbl_we === 1'b1) begin
            if (wr_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=idx%0d required=none t=%0t", bus.tbl_idx, $time);
            end else begin
                rec_t e;
                e = wr_exp.pop_front();
                chk("wr_idx", bus.tbl_idx, e.idx);
                chk("wr_taken", bus.tbl_taken, e.taken);
                if (verbose)
                    $display("write idx=%0d taken=%0d t=%0t", bus.tbl_idx, bus.tbl_taken, $time);
            end
        end
    end

    task automatic cyc(input bit v, input int idx, input bit tk, input bit pr,
                       input bit lr, input int li);
        bus.resolve_valid = v;
        bus.resolve_idx   = idx[2:0];
        bus.resolve_taken = tk;
        bus.resolve_pred  = pr;
        bus.lookup_req    = lr;
        bus.lookup_idx    = li[2:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.resolve_valid = 1'b0;
        bus.resolve_idx   = 3'd0;
        bus.resolve_taken = 1'b0;
        bus.resolve_pred  = 1'b0;
        bus.lookup_req    = 1'b0;
        bus.lookup_idx    = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single correctly predicted record, no lookup: written next cycle.
        cyc(1, 5, 1, 1, 0, 0);
        idle(3);

        // Four records under a held lookup, then a push into a full FIFO.
        for (int i = 1; i <= 4; i++) cyc(1, i, i % 2, i % 2, 1, 7 - i);
        cyc(1, 7, 1, 1, 1, 2);
        idle(6);

        // Misprediction with lookups held: flush pulse, two blocked cycles.
        cyc(1, 3, 0, 1, 1, 4);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, i);
        idle(4);

        // Reset while three records are queued in FLUSH.
        cyc(1, 2, 1, 1, 1, 1);
        cyc(1, 6, 0, 0, 1, 1);
        cyc(1, 4, 1, 0, 1, 1);
        #2 reset = 1'b1;
        bus.resolve_valid = 1'b0;
        bus.lookup_req    = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(5);

        // Randomized traffic.
        verbose = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit tk;
            tk = $urandom_range(0, 1);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), tk,
                ($urandom_range(0, 3) == 0) ? !tk : tk,
                $urandom_range(0, 1), $urandom_range(0, 7));
        end
        idle(8);

        // Drive the misprediction counter past saturation.
        for (int i = 0; i < 65540; i++) cyc(1, i % 8, 0, 1, 0, 0);
        idle(8);
        chk("cnt_saturated", bus.mispredict_cnt, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_update_scheduler.md
BRANCH_UPDATE_SCHEDULER -- requirements
Module: branch_update_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: resolve_valid  input  1  resolved branch record offered from the mem stage.
REQ-004 SHALL have port: resolve_idx  input  3  table index (pc[2:0]) of the resolved branch.
REQ-005 SHALL have port: resolve_taken  input  1  actual branch outcome.
REQ-006 SHALL have port: resolve_pred  input  1  prediction originally made for that branch.
REQ-007 SHALL have port: resolve_ready  output  1  record accepted this cycle if resolve_valid is also high.
REQ-008 SHALL have port: lookup_req  input  1  decode stage requests a predictor table read.
REQ-009 SHALL have port: lookup_idx  input  3  index for the read.
REQ-010 SHALL have port: lookup_grant  output  1  read owns the table port this cycle.
REQ-011 SHALL have port: tbl_en  output  1  table port active.
REQ-012 SHALL have port: tbl_we  output  1  table port write (update) when high, read when low.
REQ-013 SHALL have port: tbl_idx  output  3  table port index.
REQ-014 SHALL have port: tbl_taken  output  1  outcome written with the update.
REQ-015 SHALL have port: flush  output  1  one-cycle pulse on a misprediction.
REQ-016 SHALL have port: pending  output  3  records queued (0..4).
REQ-017 SHALL have port: mispredict_cnt  output  16  saturating misprediction count.
REQ-018 SHALL have the fixed FIFO depth DEPTH = 4, with no parameters exposed.

Function
REQ-019 SHALL hold records {idx, taken} in a 4-entry circular FIFO with 2-bit read/write pointers that wrap 3->0.
REQ-020 SHALL drive resolve_ready = (pending != 4), combinationally from registered state.
REQ-021 SHALL push a record on a cycle where resolve_valid && resolve_ready; a push offered while full is dropped with no state change.
REQ-022 SHALL grant the table port per cycle by priority: (a) if pending == 4 or state is FLUSH, an update wins when pending != 0; (b) else lookup_req wins; (c) else an update wins when pending != 0; (d) else the port is idle.
REQ-023 SHALL, on an update grant, drive tbl_en = 1, tbl_we = 1, and tbl_idx/tbl_taken = FIFO head, and pop the head at the clock edge.
REQ-024 SHALL, on a lookup grant, drive tbl_en = 1, tbl_we = 0, tbl_idx = lookup_idx, and lookup_grant = 1, all combinationally in the same cycle.
REQ-025 SHALL, on a simultaneous push and pop, leave pending unchanged and advance both pointers; a push into an empty FIFO is not popped in the same cycle.
REQ-026 SHALL treat an accepted record with resolve_taken != resolve_pred as a misprediction: flush = 1 on the following cycle, and mispredict_cnt increments, saturating at 16'hFFFF.
REQ-027 SHALL implement FSM states RUN and FLUSH:
  - RUN -> FLUSH on an accepted misprediction.
  - FLUSH lasts exactly 2 cycles, with lookup_grant forced to 0 and the updates draining.
  - FLUSH -> RUN after 2 cycles.
  - A further misprediction during FLUSH restarts the 2-cycle count and pulses flush again.
REQ-028 SHALL register flush; lookup_grant, resolve_ready, and tbl_* are combinational from inputs and registered state.

Reset
REQ-029 SHALL, on reset assertion (asynchronous): pointers = 0, pending = 0, state = RUN, flush = 0, mispredict_cnt = 0, and FIFO contents don't-care.
REQ-030 SHALL, while reset is high: resolve_ready = 0, lookup_grant = 0, tbl_en = 0; normal operation begins on the first posedge after deassertion.
REQ-031 SHALL, on reset mid-operation, discard queued records with no table write.

Verification
REQ-032 SHALL cover: push idx=5 taken=1 pred=1 with no lookup -> next cycle tbl_en=1, tbl_we=1, tbl_idx=5, tbl_taken=1; pending 1->0; flush stays 0.
REQ-033 SHALL cover: push 4 records while lookup_req held high -> lookup_grant=1 for 4 cycles, then pending=4, resolve_ready=0, and the next cycle gives lookup_grant=0 with an update granted.
REQ-034 SHALL cover: push taken=0 pred=1 -> flush=1 exactly one cycle later, mispredict_cnt=1, lookup_grant=0 for 2 cycles even with lookup_req=1.
REQ-035 SHALL cover: pending=4 with push and update in the same cycle -> the push is dropped (resolve_ready=0), pending=3 afterwards, the 5th record is never written.
REQ-036 SHALL cover: assert reset with pending=3 in FLUSH -> immediately pending=0, flush=0, tbl_en=0; after release, idle with no stale writes.
REQ-037 SHALL cover: force 65540 mispredictions -> mispredict_cnt holds 16'hFFFF.
